// File: rtl/prm_oblgc_pkg.sv
// ---------------------------------------------------------------------------
// prm_oblgc_pkg
// Shared types for the programmable obstacle-logic engine:
//   N_IN_DEFAULT - default occupancy width (bit 0 = A ... bit 14 = O)
//   state_e      - engine FSM states
//   term_t       - one term RAM entry {last, never, care, val}
// ---------------------------------------------------------------------------
package prm_oblgc_pkg;

    localparam int N_IN_DEFAULT = 15;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_STALL,
        ST_DONE
    } state_e;

    // Packed so it maps bit-for-bit onto cfg_wdata and the RAM word.
    typedef struct packed {
        logic                    last;   // final term of its edge
        logic                    never;  // term is constant false
        logic [N_IN_DEFAULT-1:0] care;   // bits that take part in the compare
        logic [N_IN_DEFAULT-1:0] val;    // required value of the cared bits
    } term_t;

endpackage

// File: rtl/prm_oblgc_term_ram.sv
// ---------------------------------------------------------------------------
// prm_oblgc_term_ram
// Single-port synchronous term RAM, one-cycle read latency. A write takes
// the port; otherwise a read enable loads the registered read data, which
// holds its value while re is low.
//   clk      in  : clock
//   we       in  : write strobe (wins over re)
//   re       in  : read enable
//   wr_addr  in  : write address
//   rd_addr  in  : read address
//   wdata    in  : write data
//   rdata    out : registered read data
// ---------------------------------------------------------------------------
module prm_oblgc_term_ram #(
    parameter  int DEPTH = 4096,
    parameter  int DW    = 32,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic          re,
    input  logic [AW-1:0] wr_addr,
    input  logic [AW-1:0] rd_addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] r_mem [DEPTH];
    logic [DW-1:0] r_rdata;
    logic [AW-1:0] w_addr;

    assign w_addr = we ? wr_addr : rd_addr;
    assign rdata  = r_rdata;

    // NOTE: no reset here - the array maps onto RAM macros that have no
    // reset, and the term program must survive rst_n.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[w_addr] <= wdata;
        end else if (re) begin
            r_rdata <= r_mem[w_addr];
        end
    end

endmodule

// File: rtl/prm_oblgc_engine.sv
// ---------------------------------------------------------------------------
// prm_oblgc_engine
// Walks the term RAM one term per clock, ORs term hits per edge and streams
// (edge index, mask) results under valid/ready.
//   clk, rst_n          : clock, asynchronous active-low reset
//   cfg_we/addr/wdata   : term RAM write port (ignored while busy)
//   start               : begin a pass (sampled in IDLE only)
//   occ_in, num_edge    : occupancy vector and edge count, latched on start
//   busy                : pass in progress
//   res_valid/ready     : result handshake
//   res_edge, res_mask  : edge index and blocked flag
//   done                : one-cycle end-of-pass pulse
//   err                 : sticky term-pointer overrun, cleared on start
// ---------------------------------------------------------------------------
module prm_oblgc_engine
    import prm_oblgc_pkg::*;
#(
    parameter  int N_IN       = N_IN_DEFAULT,
    parameter  int N_EDGE     = 1024,
    parameter  int TERM_DEPTH = 4096,
    localparam int EW         = $clog2(N_EDGE),
    localparam int TW         = $clog2(TERM_DEPTH),
    localparam int DW         = 2*N_IN + 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cfg_we,
    input  logic [TW-1:0]   cfg_addr,
    input  logic [DW-1:0]   cfg_wdata,
    input  logic            start,
    input  logic [N_IN-1:0] occ_in,
    input  logic [EW:0]     num_edge,
    output logic            busy,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [EW-1:0]   res_edge,
    output logic            res_mask,
    output logic            done,
    output logic            err
);

    state_e          r_state, w_state_nxt;
    logic [TW-1:0]   r_tptr;      // next address to read
    logic [TW-1:0]   r_dptr;      // address of the word now on w_rdata
    logic            r_dvld;      // w_rdata holds an unconsumed term
    logic [N_IN-1:0] r_occ;
    logic [EW:0]     r_nedge;
    logic [EW:0]     r_ecnt;      // results written so far this pass
    logic            r_acc;       // OR of hits of the current edge so far
    logic            r_res_valid;
    logic [EW-1:0]   r_res_edge;
    logic            r_res_mask;
    logic            r_err;

    logic [DW-1:0]   w_rdata;
    logic            w_last, w_never;
    logic [N_IN-1:0] w_care, w_val;
    logic            w_active, w_walk, w_hit, w_hold, w_take;
    logic            w_wr_res, w_final_hs, w_overrun, w_ram_re, w_ram_we;

    assign {w_last, w_never, w_care, w_val} = w_rdata;

    assign w_active = (r_state == ST_RUN) || (r_state == ST_STALL);
    // Walking continues until every edge has produced its result.
    assign w_walk   = w_active && (r_ecnt != r_nedge);
    assign w_hit    = !w_never && ((r_occ & w_care) == (w_val & w_care));
    // A finished edge cannot land while the output register is still full:
    // freeze the read port so the pending word stays on w_rdata.
    assign w_hold   = w_walk && r_dvld && w_last && r_res_valid && !res_ready;
    assign w_take   = w_walk && r_dvld && !w_hold;
    assign w_wr_res = w_take && w_last;
    // Reads run ahead speculatively, so overrun is judged on the consumed
    // word: the top address is only legal as the final term of the pass.
    assign w_overrun = w_take && (r_dptr == TW'(TERM_DEPTH - 1))
                       && !(w_last && ((r_ecnt + 1'b1) == r_nedge));
    assign w_final_hs = w_active && !w_walk && r_res_valid && res_ready;
    assign w_ram_re   = w_walk && !w_hold;
    assign w_ram_we   = cfg_we && !w_active;

    prm_oblgc_term_ram #(
        .DEPTH (TERM_DEPTH),
        .DW    (DW)
    ) u_term_ram (
        .clk     (clk),
        .we      (w_ram_we),
        .re      (w_ram_re),
        .wr_addr (cfg_addr),
        .rd_addr (r_tptr),
        .wdata   (cfg_wdata),
        .rdata   (w_rdata)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: next state is defaulted first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = (num_edge == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN, ST_STALL: begin
                if (w_overrun) begin
                    w_state_nxt = ST_DONE;
                end else if (w_hold) begin
                    w_state_nxt = ST_STALL;
                end else if (w_final_hs) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tptr      <= '0;
            r_dptr      <= '0;
            r_dvld      <= 1'b0;
            r_occ       <= '0;
            r_nedge     <= '0;
            r_ecnt      <= '0;
            r_acc       <= 1'b0;
            r_res_valid <= 1'b0;
            r_res_edge  <= '0;
            r_res_mask  <= 1'b0;
            r_err       <= 1'b0;
        end else if ((r_state == ST_IDLE) && start) begin
            r_occ   <= occ_in;
            r_nedge <= num_edge;
            r_ecnt  <= '0;
            r_tptr  <= '0;
            r_dvld  <= 1'b0;
            r_acc   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            if (w_ram_re) begin
                r_tptr <= r_tptr + 1'b1;
                r_dptr <= r_tptr;
            end
            r_dvld <= w_ram_re || w_hold;

            if (w_take) begin
                r_acc <= w_last ? 1'b0 : (r_acc | w_hit);
            end

            if (w_wr_res) begin
                r_res_valid <= 1'b1;
                r_res_edge  <= r_ecnt[EW-1:0];
                r_res_mask  <= r_acc | w_hit;
                r_ecnt      <= r_ecnt + 1'b1;
            end else if (r_res_valid && res_ready) begin
                r_res_valid <= 1'b0;
            end

            // An aborted pass delivers nothing further.
            if (w_overrun) begin
                r_err       <= 1'b1;
                r_res_valid <= 1'b0;
            end
        end
    end

    assign busy      = w_active;
    assign done      = (r_state == ST_DONE);
    assign res_valid = r_res_valid;
    assign res_edge  = r_res_edge;
    assign res_mask  = r_res_mask;
    assign err       = r_err;

endmodule
